// File: rtl/sar_ge_search_pkg.sv
// Shared types and constants for the successive-approximation
// greater-or-equal search initiator.
package sar_ge_search_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_CMP_LATENCY = 0;

   // Minimum of one bit so zero-latency counters stay legal.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/sar_ge_search_if.sv
// Control and comparator bundle between the search initiator
// and its surroundings.
interface sar_ge_search_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic             abort;
   logic             cmp_ge;
   logic [WIDTH-1:0] probe;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      input  start,
      input  abort,
      input  cmp_ge,
      output probe,
      output busy,
      output done,
      output result
   );

   modport slave (
      output start,
      output abort,
      output cmp_ge,
      input  probe,
      input  busy,
      input  done,
      input  result
   );

endinterface

// File: rtl/sar_ge_search.sv
// Finds an unknown value A behind an external A >= B comparator
// by testing one probe bit per comparator round, MSB first.
module sar_ge_search
   import sar_ge_search_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int CMP_LATENCY = DEF_CMP_LATENCY
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sar_ge_search_if.master       bus
);

   localparam int BW = clog2(WIDTH);
   localparam int CW = clog2(CMP_LATENCY + 1);

   localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [BW-1:0]    TOP  = BW'(WIDTH - 1);
   localparam logic [CW-1:0]    LOAD = CW'(CMP_LATENCY);

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] probe;
   logic [WIDTH-1:0] probe_n;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_n;
   logic [BW-1:0]    bit_idx;
   logic [BW-1:0]    bit_n;
   logic [CW-1:0]    wait_cnt;
   logic [CW-1:0]    cnt_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         probe    <= '0;
         result   <= '0;
         bit_idx  <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_n;
         probe    <= probe_n;
         result   <= result_n;
         bit_idx  <= bit_n;
         wait_cnt <= cnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      probe_n  = probe;
      result_n = result;
      bit_n    = bit_idx;
      cnt_n    = wait_cnt;
      unique case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               probe_n = MSB;
               bit_n   = TOP;
               cnt_n   = LOAD;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (bus.abort) begin
               probe_n = '0;
               state_n = IDLE;
            end else if (wait_cnt != '0) begin
               cnt_n = wait_cnt - 1'b1;
            end else begin
               // Trial bit is already set, so keep-or-clear is a copy.
               probe_n[bit_idx] = bus.cmp_ge;
               if (bit_idx == '0) begin
                  result_n = probe_n;
                  state_n  = DONE;
               end else begin
                  bit_n                   = bit_idx - 1'b1;
                  probe_n[bit_idx - 1'b1] = 1'b1;
                  cnt_n                   = LOAD;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.probe  = probe;
   assign bus.result = result;
   assign bus.busy   = (state == WAIT);
   assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_sar_ge_search.sv
// Scoreboard bench: two initiators (comparator latency 0 and 2)
// against behavioural A >= B responders.
module tb_sar_ge_search;

   typedef struct {
      int cyc;
      int dut;
      int sig;
      int val;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] a0;
   logic [7:0] a2;
   logic       p1;
   logic       p2;
   int         cyc;
   int         compared;
   int         mismatched;
   exp_t       q[$];

   sar_ge_search_if #(.WIDTH(8)) bus0 ();
   sar_ge_search_if #(.WIDTH(8)) bus2 ();

   sar_ge_search #(.WIDTH(8), .CMP_LATENCY(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   sar_ge_search #(.WIDTH(8), .CMP_LATENCY(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   assign bus0.cmp_ge = (a0 >= bus0.probe);

   always @(posedge clk) begin
      p1 <= (a2 >= bus2.probe);
      p2 <= p1;
   end
   assign bus2.cmp_ge = p2;

   function automatic void push(int d, int c, int s, int v);
      exp_t e;
      e.cyc = c;
      e.dut = d;
      e.sig = s;
      e.val = v;
      q.push_back(e);
   endfunction

   function automatic int act(int d, int s);
      if (d == 0) begin
         case (s)
            0: return int'(bus0.probe);
            1: return int'(bus0.result);
            2: return int'(bus0.busy);
            default: return int'(bus0.done);
         endcase
      end
      case (s)
         0: return int'(bus2.probe);
         1: return int'(bus2.result);
         2: return int'(bus2.busy);
         default: return int'(bus2.done);
      endcase
   endfunction

   function automatic string sname(int s);
      case (s)
         0: return "probe";
         1: return "result";
         2: return "busy";
         default: return "done";
      endcase
   endfunction

   // Monitor: compares due entries and flags any done not expected.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         bit seen;
         seen = 1'b0;
         foreach (q[i])
            if (q[i].dut == d && q[i].sig == 3 &&
                q[i].cyc == cyc && q[i].val == 1)
               seen = 1'b1;
         if (act(d, 3) == 1 && !seen) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done dut%0d cyc %0d: got 1 want 0",
                     d, cyc);
         end
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc <= cyc) begin
            compared++;
            if (act(q[i].dut, q[i].sig) != q[i].val) begin
               mismatched++;
               $display("FAIL %s dut%0d cyc %0d: got %0h want %0h",
                        sname(q[i].sig), q[i].dut, q[i].cyc,
                        act(q[i].dut, q[i].sig), q[i].val);
            end
            q.delete(i);
         end
      end
   end

   task automatic set_start(int d, logic v);
      if (d == 0) bus0.start = v;
      else bus2.start = v;
   endtask

   task automatic search(input int d, input logic [7:0] a,
                         input logic [63:0] seq,
                         input logic [7:0] res,
                         input int hold, input int again);
      int lat;
      int c0;
      int dn;
      @(negedge clk);
      lat = (d == 0) ? 1 : 3;
      if (d == 0) a0 = a;
      else a2 = a;
      c0 = cyc;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < lat; j++) begin
            push(d, c0 + 1 + k * lat + j, 0, int'(seq[63 - 8 * k -: 8]));
            push(d, c0 + 1 + k * lat + j, 2, 1);
         end
      dn = c0 + 8 * lat + 1;
      push(d, dn, 3, 1);
      push(d, dn, 2, 0);
      push(d, dn, 1, int'(res));
      push(d, dn, 0, int'(res));
      for (int h = 1; h <= hold; h++) begin
         push(d, dn + h, 1, int'(res));
         push(d, dn + h, 0, int'(res));
         push(d, dn + h, 2, 0);
      end
      set_start(d, 1'b1);
      for (int t = 1; t <= dn - c0 + hold + 1; t++) begin
         @(negedge clk);
         if (t == 1) set_start(d, 1'b0);
         if (again != 0 && t == again) set_start(d, 1'b1);
         if (again != 0 && t == again + 1) set_start(d, 1'b0);
      end
   endtask

   task automatic abort_run(input int at, input logic [7:0] prev);
      int c0;
      logic [63:0] seq;
      seq = 64'h80_40_60_50_58_5C_5A_5B;
      @(negedge clk);
      a0 = 8'h5A;
      c0 = cyc;
      for (int k = 0; k < at; k++) begin
         push(0, c0 + 1 + k, 0, int'(seq[63 - 8 * k -: 8]));
         push(0, c0 + 1 + k, 2, 1);
      end
      push(0, c0 + at + 1, 2, 0);
      push(0, c0 + at + 1, 0, 0);
      push(0, c0 + at + 1, 1, int'(prev));
      push(0, c0 + 9, 3, 0);
      push(0, c0 + 9, 1, int'(prev));
      bus0.start = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk);
         if (t == 1) bus0.start = 1'b0;
         if (t == at) bus0.abort = 1'b1;
         if (t == at + 1) bus0.abort = 1'b0;
      end
   endtask

   task automatic reset_run(input int at);
      int c0;
      @(negedge clk);
      a0 = 8'h5A;
      c0 = cyc;
      push(0, c0 + 1, 0, 8'h80);
      push(0, c0 + 1, 2, 1);
      for (int d = 0; d < 2; d++) begin
         push(d, c0 + at + 1, 0, 0);
         push(d, c0 + at + 1, 1, 0);
         push(d, c0 + at + 1, 2, 0);
         push(d, c0 + at + 1, 3, 0);
      end
      push(0, c0 + 9, 3, 0);
      bus0.start = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk);
         if (t == 1) bus0.start = 1'b0;
         if (t == at) rst_n = 1'b0;
         if (t == at + 1) rst_n = 1'b1;
      end
   endtask

   task automatic start_abort_idle();
      int c0;
      @(negedge clk);
      c0 = cyc;
      for (int t = 1; t <= 5; t++) begin
         push(0, c0 + t, 2, 0);
         push(0, c0 + t, 0, 0);
      end
      bus0.start = 1'b1;
      bus0.abort = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      bus0.abort = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      a0         = 8'h00;
      a2         = 8'h00;
      p1         = 1'b0;
      p2         = 1'b0;
      bus0.start = 1'b0;
      bus0.abort = 1'b0;
      bus2.start = 1'b0;
      bus2.abort = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++)
         for (int s = 0; s < 4; s++)
            push(d, cyc + 1, s, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      search(0, 8'h5A, 64'h80_40_60_50_58_5C_5A_5B, 8'h5A, 2, 0);
      search(0, 8'h00, 64'h80_40_20_10_08_04_02_01, 8'h00, 20, 0);
      search(0, 8'hFF, 64'h80_C0_E0_F0_F8_FC_FE_FF, 8'hFF, 20, 0);
      search(1, 8'h37, 64'h80_40_20_30_38_34_36_37, 8'h37, 3, 0);
      search(0, 8'h5A, 64'h80_40_60_50_58_5C_5A_5B, 8'h5A, 3, 3);
      abort_run(4, 8'h5A);
      search(0, 8'h5A, 64'h80_40_60_50_58_5C_5A_5B, 8'h5A, 2, 0);
      reset_run(4);
      start_abort_idle();

      for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
      if (q.size() != 0) begin
         compared   += q.size();
         mismatched += q.size();
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sar_ge_search.md
Name: sar_ge_search

Overview:
- Initiator side of an unsigned greater-or-equal comparator interface.
- Finds an unknown unsigned value A held on the far side of an external A >= B comparator by successive approximation. It drives probe values on B and reads back the comparator result.
- Sits between control logic and any threshold or compare resource: ADC-style threshold search, calibration trim search, or recovering a register value through a compare-only port.
- Result: the largest probe for which the comparator reports A >= probe, i.e. A itself.

Parameters:
- WIDTH, 8, bit width of probe and result.
- CMP_LATENCY, 0, clock cycles between a probe change and a valid cmp_ge. 0 means a combinational comparator.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new search; accepted only in IDLE.
- abort  input  1  cancel a search in progress.
- cmp_ge  input  1  comparator result: 1 when A >= probe.
- probe  output  WIDTH  trial value driven to the comparator B input.
- busy  output  1  high while a search is running.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  found value; held until the next accepted start.

Behaviour:
- Reset: one clock and one synchronous active-low reset. rst_n is sampled on the rising edge of clk; with rst_n=0 at an edge the block enters IDLE.
- Reset values: probe=0, result=0, busy=0, done=0; internal bit index and wait counter cleared.
- Reset mid-search discards all progress and does not pulse done.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - start=1 loads probe = 1<<(WIDTH-1), bit_idx = WIDTH-1, wait_cnt = CMP_LATENCY, then goes to WAIT.
  - busy rises in the cycle after start is sampled.
- WAIT (busy=1):
  - If wait_cnt != 0: decrement it; probe is held stable.
  - If wait_cnt == 0, sample cmp_ge:
    - cmp_ge=0 clears probe[bit_idx]; cmp_ge=1 keeps it.
    - If bit_idx == 0: result <= updated probe, go to DONE.
    - Otherwise: bit_idx decrements, the next lower bit is set in probe, wait_cnt reloads to CMP_LATENCY.
- DONE:
  - done=1 for exactly one cycle, busy=0, then return to IDLE.
  - probe holds the final value until the next start.
- Latency:
  - WIDTH*(CMP_LATENCY+1) cycles in WAIT.
  - done asserts on cycle WIDTH*(CMP_LATENCY+1)+1 after the start edge, counting the first WAIT cycle as 1.
  - For WIDTH=8, CMP_LATENCY=0: done on cycle 9.
- start while busy or in DONE is ignored. It is not queued.
- abort:
  - In WAIT, abort returns to IDLE next cycle: busy=0, no done pulse, result unchanged, probe <= 0.
  - abort in IDLE or DONE has no effect.
  - abort and start together in IDLE: abort wins and nothing starts.
- Arithmetic: pure bit set/clear on probe; no adders and no overflow.
- Boundary results:
  - A=0 yields result 0 with every probe bit rejected.
  - A=2^WIDTH-1 yields all ones.
- cmp_ge is ignored outside WAIT and in WAIT cycles where wait_cnt != 0.

Decomposition:
- Shared package holds:
  - state enum {IDLE, WAIT, DONE}.
  - default WIDTH / CMP_LATENCY constants.
  - bit-index width function clog2(WIDTH).
- No sub-module: a single FSM plus the wait counter is natural.
- The bench supplies the responder: the team's 8-bit unsigned >= comparator with A driven from the testbench. An optional pipeline stage models CMP_LATENCY.

Test Plan:
- A=0x5A, CMP_LATENCY=0, pulse start:
  - probe sequence 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A,0x5B, one per cycle.
  - done on cycle 9, result=0x5A, busy low after.
- A=0x00 -> result 0x00. A=0xFF -> result 0xFF, probe sequence 0x80,0xC0,...,0xFF. Both: done exactly one cycle, result held across 20 idle cycles.
- CMP_LATENCY=2, A=0x37, comparator pipelined 2 cycles:
  - each probe held 3 cycles.
  - done on cycle 25, result=0x37.
- Pulse start again at cycle 3 of a search with A=0x5A -> ignored; single done, result 0x5A.
- Ordered disturbance run, A=0x5A:
  - abort at cycle 4 -> busy drops, no done, result keeps the previous value.
  - restart with A=0x5A -> done at cycle 9, result 0x5A.
  - drive rst_n=0 mid-search -> all outputs 0 next edge, no done.
- start and abort asserted together in IDLE -> stays IDLE, busy stays 0.
